// File: rtl/fft_axil_pkg.sv
// Shared constants and FSM state types for the FFT AXI4-Lite register file.
package fft_axil_pkg;

    // AXI response codes
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Register indices
    localparam int REG_CTRL     = 0;
    localparam int REG_STATUS   = 1;
    localparam int REG_CFG_BASE = 2;

    // CTRL bit positions
    localparam int CTRL_START_BIT  = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;

    // STATUS bit positions
    localparam int STATUS_BUSY_BIT = 0;
    localparam int STATUS_DONE_BIT = 1;

    // Write channel FSM: collect AW/W, then hold the response
    typedef enum logic {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } wr_state_t;

    // Read channel FSM: accept AR, then hold the data beat
    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

endpackage

// File: rtl/fft_axil_regfile.sv
// AXI4-Lite register file fronting an FFT core: CTRL/STATUS plus a bank of
// general configuration registers exported flat on cfg_o.
module fft_axil_regfile
    import fft_axil_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_NUM_REGS         = 8,
    parameter int C_S_AXI_ADDR_WIDTH = $clog2(C_NUM_REGS) + $clog2(C_S_AXI_DATA_WIDTH / 8)
) (
    input  logic                                         S_AXI_ACLK,
    input  logic                                         S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]                S_AXI_AWADDR,
    input  logic [2:0]                                   S_AXI_AWPROT,
    input  logic                                         S_AXI_AWVALID,
    output logic                                         S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]                S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]              S_AXI_WSTRB,
    input  logic                                         S_AXI_WVALID,
    output logic                                         S_AXI_WREADY,
    output logic [1:0]                                   S_AXI_BRESP,
    output logic                                         S_AXI_BVALID,
    input  logic                                         S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]                S_AXI_ARADDR,
    input  logic [2:0]                                   S_AXI_ARPROT,
    input  logic                                         S_AXI_ARVALID,
    output logic                                         S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]                S_AXI_RDATA,
    output logic [1:0]                                   S_AXI_RRESP,
    output logic                                         S_AXI_RVALID,
    input  logic                                         S_AXI_RREADY,
    input  logic                                         busy_i,
    input  logic                                         done_i,
    output logic                                         start_o,
    output logic                                         irq_o,
    output logic [(C_NUM_REGS-2)*C_S_AXI_DATA_WIDTH-1:0] cfg_o
);

    localparam int DW    = C_S_AXI_DATA_WIDTH;
    localparam int STRBW = DW / 8;
    localparam int LSB   = $clog2(STRBW);
    localparam int IDXW  = C_S_AXI_ADDR_WIDTH - LSB;
    localparam int NCFG  = C_NUM_REGS - REG_CFG_BASE;
    localparam int FLATW = NCFG * DW;
    localparam int SELW  = $clog2(FLATW);

    // Byte-lane merge: strobed lanes take the new data, others keep old.
    function automatic logic [DW-1:0] f_merge(input logic [DW-1:0]    old_v,
                                              input logic [DW-1:0]    new_v,
                                              input logic [STRBW-1:0] strb);
        logic [DW-1:0] v;
        v = old_v;
        for (int b = 0; b < STRBW; b++) begin
            if (strb[b]) begin
                v[b*8 +: 8] = new_v[b*8 +: 8];
            end
        end
        return v;
    endfunction

    // Write path state
    wr_state_t          r_wstate;
    logic               r_aw_valid;
    logic [IDXW-1:0]    r_aw_idx;
    logic               r_w_valid;
    logic [DW-1:0]      r_wdata;
    logic [STRBW-1:0]   r_wstrb;
    logic               r_bvalid;
    logic [1:0]         r_bresp;

    // Read path state
    rd_state_t          r_rstate;
    logic               r_rvalid;
    logic [DW-1:0]      r_rdata;
    logic [1:0]         r_rresp;

    // CTRL / STATUS storage
    logic               r_irq_en;
    logic               r_done;
    logic               r_start;
    logic               r_irq;

    // Combinational helpers
    logic               w_awready;
    logic               w_wready;
    logic               w_arready;
    logic               w_commit;
    int                 w_aw_idx;
    logic               w_aw_in_range;
    logic               w_wr_ctrl;
    logic               w_wr_status;
    logic [FLATW-1:0]   w_cfg_flat;
    int                 w_ar_idx;
    logic [SELW-1:0]    w_rd_sel;
    logic [DW-1:0]      w_rd_data;
    logic [1:0]         w_rd_resp;
    logic               w_unused;

    // Protection bits and sub-word address bits carry no meaning here.
    assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                        S_AXI_AWADDR[LSB-1:0], S_AXI_ARADDR[LSB-1:0]};

    // Ready outputs are gated by reset so they drop the instant reset asserts
    // and rise again in the very first cycle after release.
    assign w_awready = !S_AXI_ARESET && (r_wstate == W_IDLE) && !r_aw_valid;
    assign w_wready  = !S_AXI_ARESET && (r_wstate == W_IDLE) && !r_w_valid;
    assign w_arready = !S_AXI_ARESET && (r_rstate == R_IDLE);

    assign w_commit      = (r_wstate == W_IDLE) && r_aw_valid && r_w_valid;
    assign w_aw_idx      = int'(r_aw_idx);
    assign w_aw_in_range = (w_aw_idx < C_NUM_REGS);
    assign w_wr_ctrl     = w_commit && (w_aw_idx == REG_CTRL)   && r_wstrb[0];
    assign w_wr_status   = w_commit && (w_aw_idx == REG_STATUS) && r_wstrb[0];

    // Write channel: latch AW and W independently, commit once both are
    // held, then present the response until the master takes it.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            r_wstate   <= W_IDLE;
            r_aw_valid <= 1'b0;
            r_aw_idx   <= '0;
            r_w_valid  <= 1'b0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_bvalid   <= 1'b0;
            r_bresp    <= RESP_OKAY;
        end else if (r_wstate == W_IDLE) begin
            if (S_AXI_AWVALID && !r_aw_valid) begin
                r_aw_valid <= 1'b1;
                r_aw_idx   <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:LSB];
            end
            if (S_AXI_WVALID && !r_w_valid) begin
                r_w_valid <= 1'b1;
                r_wdata   <= S_AXI_WDATA;
                r_wstrb   <= S_AXI_WSTRB;
            end
            if (w_commit) begin
                r_aw_valid <= 1'b0;
                r_w_valid  <= 1'b0;
                r_bvalid   <= 1'b1;
                r_bresp    <= w_aw_in_range ? RESP_OKAY : RESP_SLVERR;
                r_wstate   <= W_RESP;
            end
        end else begin
            if (S_AXI_BREADY) begin
                r_bvalid <= 1'b0;
                r_bresp  <= RESP_OKAY;
                r_wstate <= W_IDLE;
            end
        end
    end

    // General configuration registers, one flop bank per index, each
    // exported straight onto its slice of cfg_o.
    for (genvar gi = 0; gi < NCFG; gi++) begin : g_cfg
        logic [DW-1:0] r_cfg;

        // Byte-strobed update when the committed write targets this index
        always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
            if (S_AXI_ARESET) begin
                r_cfg <= '0;
            end else if (w_commit && (w_aw_idx == gi + REG_CFG_BASE)) begin
                r_cfg <= f_merge(r_cfg, r_wdata, r_wstrb);
            end
        end

        assign w_cfg_flat[gi*DW +: DW] = r_cfg;
    end

    assign cfg_o = w_cfg_flat;

    // CTRL/STATUS: START pulse, IRQ enable, sticky DONE and registered irq.
    // A done_i cycle wins over a coincident W1C so no completion is lost.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            r_start  <= 1'b0;
            r_irq_en <= 1'b0;
            r_done   <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            r_start <= w_wr_ctrl && r_wdata[CTRL_START_BIT] && !busy_i;
            if (w_wr_ctrl) begin
                r_irq_en <= r_wdata[CTRL_IRQ_EN_BIT];
            end
            r_done <= done_i || (r_done && !(w_wr_status && r_wdata[STATUS_DONE_BIT]));
            r_irq  <= r_done && r_irq_en;
        end
    end

    // Read data selection for the address currently on the AR channel.
    always_comb begin
        w_ar_idx  = int'(S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:LSB]);
        w_rd_sel  = '0;
        w_rd_data = '0;
        w_rd_resp = RESP_OKAY;
        if (w_ar_idx >= C_NUM_REGS) begin
            w_rd_resp = RESP_SLVERR;
        end else if (w_ar_idx == REG_CTRL) begin
            w_rd_data[CTRL_IRQ_EN_BIT] = r_irq_en;
        end else if (w_ar_idx == REG_STATUS) begin
            w_rd_data[STATUS_BUSY_BIT] = busy_i;
            w_rd_data[STATUS_DONE_BIT] = r_done;
        end else begin
            w_rd_sel  = SELW'((w_ar_idx - REG_CFG_BASE) * DW);
            w_rd_data = w_cfg_flat[w_rd_sel +: DW];
        end
    end

    // Read channel: capture the selected word at the AR handshake and hold
    // it until the master accepts. Same-cycle writes are seen next read.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            r_rstate <= R_IDLE;
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rresp  <= RESP_OKAY;
        end else if (r_rstate == R_IDLE) begin
            if (S_AXI_ARVALID) begin
                r_rstate <= R_DATA;
                r_rvalid <= 1'b1;
                r_rdata  <= w_rd_data;
                r_rresp  <= w_rd_resp;
            end
        end else begin
            if (S_AXI_RREADY) begin
                r_rstate <= R_IDLE;
                r_rvalid <= 1'b0;
                r_rdata  <= '0;
                r_rresp  <= RESP_OKAY;
            end
        end
    end

    assign S_AXI_AWREADY = w_awready;
    assign S_AXI_WREADY  = w_wready;
    assign S_AXI_BVALID  = r_bvalid;
    assign S_AXI_BRESP   = r_bresp;
    assign S_AXI_ARREADY = w_arready;
    assign S_AXI_RVALID  = r_rvalid;
    assign S_AXI_RDATA   = r_rdata;
    assign S_AXI_RRESP   = r_rresp;
    assign start_o       = r_start;
    assign irq_o         = r_irq;

endmodule

// File: tb/tb_fft_axil_regfile.sv
// Bench for fft_axil_regfile: a 32-bit and a 64-bit instance (6 registers
// each) share one stimulus driver; mode64 selects which one is active.
module tb_fft_axil_regfile;

    localparam int NREGS = 6;
    localparam int A32   = 5;
    localparam int A64   = 6;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    int          start_cnt = 0;
    bit          mode64 = 1'b0;

    int          aw_idx = 0, aw_off = 0, ar_idx = 0, ar_off = 0;
    logic        awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
    logic [63:0] wdata = '0;
    logic [7:0]  wstrb = '0;
    logic        busy = 0, done = 0;

    // 32-bit instance signals
    logic [A32-1:0] awaddr32, araddr32;
    logic           awready32, wready32, bvalid32, arready32, rvalid32, start32, irq32;
    logic [1:0]     bresp32, rresp32;
    logic [31:0]    rdata32;
    logic [4*32-1:0] cfg32;

    // 64-bit instance signals
    logic [A64-1:0] awaddr64, araddr64;
    logic           awready64, wready64, bvalid64, arready64, rvalid64, start64, irq64;
    logic [1:0]     bresp64, rresp64;
    logic [63:0]    rdata64;
    logic [4*64-1:0] cfg64;

    assign awaddr32 = A32'(aw_idx * 4 + aw_off);
    assign araddr32 = A32'(ar_idx * 4 + ar_off);
    assign awaddr64 = A64'(aw_idx * 8 + aw_off);
    assign araddr64 = A64'(ar_idx * 8 + ar_off);

    fft_axil_regfile #(.C_S_AXI_DATA_WIDTH(32), .C_NUM_REGS(NREGS)) dut32 (
        .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
        .S_AXI_AWADDR(awaddr32), .S_AXI_AWPROT(3'b000),
        .S_AXI_AWVALID(awvalid && !mode64), .S_AXI_AWREADY(awready32),
        .S_AXI_WDATA(wdata[31:0]), .S_AXI_WSTRB(wstrb[3:0]),
        .S_AXI_WVALID(wvalid && !mode64), .S_AXI_WREADY(wready32),
        .S_AXI_BRESP(bresp32), .S_AXI_BVALID(bvalid32), .S_AXI_BREADY(bready && !mode64),
        .S_AXI_ARADDR(araddr32), .S_AXI_ARPROT(3'b000),
        .S_AXI_ARVALID(arvalid && !mode64), .S_AXI_ARREADY(arready32),
        .S_AXI_RDATA(rdata32), .S_AXI_RRESP(rresp32), .S_AXI_RVALID(rvalid32),
        .S_AXI_RREADY(rready && !mode64),
        .busy_i(busy), .done_i(done), .start_o(start32), .irq_o(irq32), .cfg_o(cfg32)
    );

    fft_axil_regfile #(.C_S_AXI_DATA_WIDTH(64), .C_NUM_REGS(NREGS)) dut64 (
        .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
        .S_AXI_AWADDR(awaddr64), .S_AXI_AWPROT(3'b000),
        .S_AXI_AWVALID(awvalid && mode64), .S_AXI_AWREADY(awready64),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb),
        .S_AXI_WVALID(wvalid && mode64), .S_AXI_WREADY(wready64),
        .S_AXI_BRESP(bresp64), .S_AXI_BVALID(bvalid64), .S_AXI_BREADY(bready && mode64),
        .S_AXI_ARADDR(araddr64), .S_AXI_ARPROT(3'b000),
        .S_AXI_ARVALID(arvalid && mode64), .S_AXI_ARREADY(arready64),
        .S_AXI_RDATA(rdata64), .S_AXI_RRESP(rresp64), .S_AXI_RVALID(rvalid64),
        .S_AXI_RREADY(rready && mode64),
        .busy_i(busy), .done_i(done), .start_o(start64), .irq_o(irq64), .cfg_o(cfg64)
    );

    // Active-instance view
    logic        o_awready, o_wready, o_bvalid, o_arready, o_rvalid, o_start, o_irq;
    logic [1:0]  o_bresp, o_rresp;
    logic [63:0] o_rdata;
    assign o_awready = mode64 ? awready64 : awready32;
    assign o_wready  = mode64 ? wready64  : wready32;
    assign o_bvalid  = mode64 ? bvalid64  : bvalid32;
    assign o_bresp   = mode64 ? bresp64   : bresp32;
    assign o_arready = mode64 ? arready64 : arready32;
    assign o_rvalid  = mode64 ? rvalid64  : rvalid32;
    assign o_rresp   = mode64 ? rresp64   : rresp32;
    assign o_rdata   = mode64 ? rdata64   : {32'h0, rdata32};
    assign o_start   = mode64 ? start64   : start32;
    assign o_irq     = mode64 ? irq64     : irq32;

    // Count cycles in which start_o is high
    always @(posedge clk) if (o_start) start_cnt <= start_cnt + 1;

    // Behavioural reference model of the register map
    logic [63:0] m_reg [0:7];
    bit          m_irq_en, m_done;

    function automatic int nbytes();
        return mode64 ? 8 : 4;
    endfunction

    function automatic logic [1:0] m_resp(input int idx);
        return (idx < NREGS) ? 2'b00 : 2'b10;
    endfunction

    function automatic logic [63:0] m_read(input int idx);
        if (idx >= NREGS) return 64'h0;
        if (idx == 0)     return {62'h0, m_irq_en, 1'b0};
        if (idx == 1)     return {62'h0, m_done, busy};
        return m_reg[idx];
    endfunction

    task automatic m_write(input int idx, input logic [63:0] d, input logic [7:0] s);
        if (idx >= NREGS) return;
        if (idx == 0) begin
            if (s[0]) m_irq_en = d[1];
        end else if (idx == 1) begin
            if (s[0] && d[1]) m_done = 0;
        end else begin
            for (int b = 0; b < nbytes(); b++)
                if (s[b]) m_reg[idx][b*8 +: 8] = d[b*8 +: 8];
        end
    endtask

    task automatic m_clear();
        for (int i = 0; i < 8; i++) m_reg[i] = '0;
        m_irq_en = 0;
        m_done   = 0;
    endtask

    function automatic logic [63:0] get_cfg(input int k);
        if (mode64) return cfg64[(k-2)*64 +: 64];
        return {32'h0, cfg32[(k-2)*32 +: 32]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s dw=%0d observed=%0h expected=%0h", tag, mode64 ? 64 : 32, obs, exp);
        end
    endtask

    // Raw AXI write with per-channel delays; b_dly = cycles BREADY stays low
    // after BVALID is first seen. lat = samples from AW handshake to BVALID.
    task automatic axi_write(input int idx, input int off, input logic [63:0] data,
                             input logic [7:0] strb, input int aw_dly, input int w_dly,
                             input int b_dly, output logic [1:0] resp, output int lat,
                             output bit held, output bit ok);
        int cyc = 0, aw_cyc = -1, bv_first = -1, bv_cnt = 0;
        bit aw_done = 0, w_done = 0, b_done = 0, hs_aw, hs_w, hs_b;
        held = 1; resp = 2'b11;
        aw_idx = idx; aw_off = off; wdata = data; wstrb = strb;
        while (!b_done && cyc < 80) begin
            awvalid = !aw_done && (cyc >= aw_dly);
            wvalid  = !w_done && (cyc >= w_dly);
            bready  = o_bvalid && (bv_cnt >= b_dly);
            hs_aw = awvalid && o_awready;
            hs_w  = wvalid && o_wready;
            hs_b  = bready;
            if (o_bvalid) begin
                if (bv_first < 0) bv_first = cyc;
                resp = o_bresp;
                bv_cnt++;
            end else if (bv_first >= 0) begin
                held = 0;
            end
            tick();
            cyc++;
            if (hs_aw) begin aw_done = 1; aw_cyc = cyc; end
            if (hs_w)  w_done = 1;
            if (hs_b)  b_done = 1;
        end
        awvalid = 0; wvalid = 0; bready = 0;
        lat  = bv_first - aw_cyc;
        ok   = b_done;
        held = held && (bv_cnt > b_dly);
    endtask

    // Raw AXI read; lat = samples from AR handshake to RVALID (0 = next cycle).
    task automatic axi_read(input int idx, input int off, input int r_dly,
                            output logic [63:0] data, output logic [1:0] resp,
                            output int lat, output bit ok);
        int cyc = 0, ar_cyc = -1, rv_first = -1, rv_cnt = 0;
        bit ar_done = 0, r_done = 0, hs_ar, hs_r;
        data = 'x; resp = 2'b11;
        ar_idx = idx; ar_off = off;
        while (!r_done && cyc < 80) begin
            arvalid = !ar_done;
            rready  = o_rvalid && (rv_cnt >= r_dly);
            hs_ar = arvalid && o_arready;
            hs_r  = rready;
            if (o_rvalid) begin
                if (rv_first < 0) rv_first = cyc;
                data = o_rdata;
                resp = o_rresp;
                rv_cnt++;
            end
            tick();
            cyc++;
            if (hs_ar) begin ar_done = 1; ar_cyc = cyc; end
            if (hs_r)  r_done = 1;
        end
        arvalid = 0; rready = 0;
        lat = rv_first - ar_cyc;
        ok  = r_done;
    endtask

    task automatic do_write(input string tag, input int idx, input int off,
                            input logic [63:0] data, input logic [7:0] strb,
                            input int aw_dly, input int w_dly, input int b_dly,
                            output int lat, output bit held);
        logic [1:0] resp; bit ok;
        axi_write(idx, off, data, strb, aw_dly, w_dly, b_dly, resp, lat, held, ok);
        check({tag, "_bdone"}, 64'(ok), 64'd1);
        check({tag, "_bresp"}, 64'(resp), 64'(m_resp(idx)));
        m_write(idx, data, strb);
        $display("WR %s dw=%0d idx=%0d data=%0h strb=%0h bresp=%0d", tag,
                 mode64 ? 64 : 32, idx, data, strb, resp);
    endtask

    task automatic do_read(input string tag, input int idx, input int off, input int r_dly,
                           output logic [63:0] data);
        logic [1:0] resp; int lat; bit ok;
        axi_read(idx, off, r_dly, data, resp, lat, ok);
        check({tag, "_rdone"}, 64'(ok), 64'd1);
        check({tag, "_rresp"}, 64'(resp), 64'(m_resp(idx)));
        check({tag, "_rdata"}, data, m_read(idx));
        check({tag, "_rlat"}, 64'(lat), 64'd0);
        $display("RD %s dw=%0d idx=%0d data=%0h rresp=%0d", tag, mode64 ? 64 : 32, idx, data, resp);
    endtask

    // Assert reset (checking outputs drop at once), release it and check
    // that the channels are immediately ready again.
    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        check({tag, "_awready"}, 64'(o_awready), 64'd0);
        check({tag, "_wready"},  64'(o_wready),  64'd0);
        check({tag, "_arready"}, 64'(o_arready), 64'd0);
        check({tag, "_bvalid"},  64'(o_bvalid),  64'd0);
        check({tag, "_rvalid"},  64'(o_rvalid),  64'd0);
        check({tag, "_outs"},    {o_rdata[59:0], o_bresp, o_rresp} ^ 64'(o_start) ^ 64'(o_irq), 64'd0);
        for (int k = 2; k < NREGS; k++) check({tag, "_cfg"}, get_cfg(k), 64'd0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check({tag, "_awready_rel"}, 64'(o_awready), 64'd1);
        check({tag, "_arready_rel"}, 64'(o_arready), 64'd1);
        m_clear();
        $display("RST %s dw=%0d", tag, mode64 ? 64 : 32);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] d, rd;
        int lat, s0, idx;
        bit held;
        m_clear();
        tick();
        for (int m = 0; m < 2; m++) begin
            mode64 = (m == 1);
            busy = 0; done = 0;
            do_reset("init");

            // Full-word write and readback of reg2
            d = mode64 ? 64'h1357_9BDF_A5A5_0001 : 64'h0000_0000_A5A5_0001;
            do_write("r2", 2, 0, d, 8'hFF, 0, 0, 0, lat, held);
            do_read("r2", 2, 0, 0, rd);
            check("r2_const", rd, d);
            check("r2_cfg", get_cfg(2), d);

            // Single-lane strobe; W leads AW by 3 cycles
            do_write("r3_strb", 3, 0, 64'hFFFF_FFFF_FFFF_FFFF, 8'h02, 3, 0, 0, lat, held);
            check("r3_blat", 64'(lat), 64'd1);
            do_read("r3_strb", 3, 0, 0, rd);
            check("r3_const", rd, 64'h0000_FF00);

            // START pulse, DONE sticky, irq one cycle behind DONE, W1C clears
            s0 = start_cnt;
            do_write("ctrl_go", 0, 0, 64'h3, 8'hFF, 0, 0, 0, lat, held);
            tick(); tick(); tick();
            check("start_pulse", 64'(start_cnt - s0), 64'd1);
            do_read("ctrl_rd", 0, 0, 0, rd);
            done = 1; tick(); done = 0; m_done = 1;
            check("irq_lag", 64'(o_irq), 64'd0);
            tick();
            check("irq_set", 64'(o_irq), 64'd1);
            do_read("status_done", 1, 0, 0, rd);
            check("status_const", rd, 64'h2);
            do_write("w1c", 1, 0, 64'h2, 8'hFF, 0, 0, 0, lat, held);
            tick();
            check("irq_clr", 64'(o_irq), 64'd0);

            // START ignored while busy, IRQ_EN still updates
            busy = 1;
            s0 = start_cnt;
            do_write("ctrl_busy", 0, 0, 64'h1, 8'hFF, 0, 0, 0, lat, held);
            tick(); tick(); tick();
            check("start_busy", 64'(start_cnt - s0), 64'd0);
            do_read("ctrl_busy", 0, 0, 0, rd);

            // done_i coincident with W1C keeps DONE set
            done = 1; tick(); m_done = 1;
            do_write("w1c_race", 1, 0, 64'h2, 8'hFF, 0, 0, 0, lat, held);
            done = 0; m_done = 1;
            do_read("status_race", 1, 0, 0, rd);
            check("status_race_const", rd, 64'h3);
            busy = 0;

            // Reserved/read-only bits ignored
            do_write("ctrl_rsvd", 0, 0, 64'hFFFF_FFFF_FFFF_FFFC, 8'hFF, 0, 0, 0, lat, held);
            do_read("ctrl_rsvd", 0, 0, 0, rd);
            do_write("status_ro", 1, 0, 64'h1, 8'hFF, 0, 0, 0, lat, held);
            do_read("status_ro", 1, 0, 0, rd);

            // Out-of-range write and read; BREADY held low 5 cycles
            d = {$urandom, $urandom};
            do_write("oor_wr", 7, 0, d, 8'hFF, 0, 0, 5, lat, held);
            check("oor_bheld", 64'(held), 64'd1);
            do_write("oor6_wr", 6, 0, d, 8'hFF, 1, 2, 0, lat, held);
            for (int k = 2; k < NREGS; k++) check("oor_cfg", get_cfg(k), m_reg[k]);
            do_read("oor_rd", 7, 0, 0, rd);
            do_read("oor6_rd", 6, 0, 2, rd);

            // Byte offset bits ignored
            d = {$urandom, $urandom};
            do_write("offs", 4, 3, d, 8'hFF, 0, 1, 0, lat, held);
            do_read("offs", 4, 1, 0, rd);

            // Reset while BVALID is pending
            aw_idx = 2; aw_off = 0; wdata = 64'hDEAD_BEEF_1234_5678; wstrb = 8'hFF;
            awvalid = 1; wvalid = 1; bready = 0;
            tick();
            awvalid = 0; wvalid = 0;
            for (int c = 0; c < 10 && !o_bvalid; c++) tick();
            check("midrst_bvalid_pre", 64'(o_bvalid), 64'd1);
            do_reset("midrst");
            d = {$urandom, $urandom};
            do_write("post_rst", 2, 0, d, 8'hFF, 0, 0, 0, lat, held);
            do_read("post_rst", 2, 0, 0, rd);

            // Randomised traffic against the model
            for (int t = 0; t < 40; t++) begin
                busy = 1'($urandom_range(0, 1));
                idx  = $urandom_range(0, 7);
                if ($urandom_range(0, 1) == 1) begin
                    do_write("rnd", idx, $urandom_range(0, 3), {$urandom, $urandom},
                             8'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                             $urandom_range(0, 2), lat, held);
                    check("rnd_irq", 64'(o_irq), 64'(m_done && m_irq_en));
                end else begin
                    do_read("rnd", idx, $urandom_range(0, 3), $urandom_range(0, 2), rd);
                end
            end
            for (int k = 2; k < NREGS; k++) check("rnd_cfg", get_cfg(k), m_reg[k]);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
